wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources:
  - the delayed DSP execution result (EX path);
  - the data-memory load return (DM path).
- DM has fixed priority. An EX write that loses arbitration goes into a small in-order deferral FIFO, which drains on idle port cycles.
- Sits between the EX output delay line / data-memory return and the register file. Raises a stall to fetch when the FIFO nears capacity.

---
 rtl/wb_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: DM load returns have fixed priority, and losing EX writes wait in an in-order deferral FIFO.
// Optional forwarding lookup into the deferral FIFO is enabled by defining WB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_we_i,
  input  logic [ADDR_W-1:0]        ex_addr_i,
  input  logic [DATA_W-1:0]        ex_data_i,
  input  logic                     dm_we_i,
  input  logic [ADDR_W-1:0]        dm_addr_i,
  input  logic [DATA_W-1:0]        dm_data_i,
  output logic                     rf_we_o,
  output logic [ADDR_W-1:0]        rf_addr_o,
  output logic [DATA_W-1:0]        rf_data_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  input  logic [ADDR_W-1:0]        rs_addr_i,
  output logic                     rs_hit_o,
  output logic [DATA_W-1:0]        rs_data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [PTR_W-1:0]  occ, occ_next;
  logic              empty, full, pop, defer, push, drop;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // Same slot index but different wrap bit means every slot is occupied.
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // Order within a cycle is DM, then FIFO head, then new EX; EX must queue
  // behind anything older to keep program order.
  assign pop      = !dm_we_i && !empty;
  assign defer    = ex_we_i && (dm_we_i || !empty);
  assign push     = defer && (!full || pop);
  assign drop     = defer && full && !pop;
  assign occ_next = occ + PTR_W'(push) - PTR_W'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
      stall_o   <= 1'b0;
      ovf_o     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      // NOTE: only the valid bits need reset; payload is never read while invalid.
      for (int i = 0; i < DEPTH; i++) fifo_q[i].valid <= 1'b0;
    end else begin
      if (dm_we_i) begin
        rf_we_o   <= 1'b1;
        rf_addr_o <= dm_addr_i;
        rf_data_o <= dm_data_i;
      end else if (!empty) begin
        rf_we_o <= fifo_q[rd_idx].valid;
        if (fifo_q[rd_idx].valid) begin
          rf_addr_o <= fifo_q[rd_idx].addr;
          rf_data_o <= fifo_q[rd_idx].data;
        end
      end else if (ex_we_i) begin
        rf_we_o   <= 1'b1;
        rf_addr_o <= ex_addr_i;
        rf_data_o <= ex_data_i;
      end else begin
        rf_we_o <= 1'b0;
      end

      // A DM write is newer than any buffered EX data for the same register.
      if (dm_we_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_q[i].valid && (fifo_q[i].addr == dm_addr_i))
            fifo_q[i].valid <= 1'b0;
        end
      end

      if (pop) begin
        fifo_q[rd_idx].valid <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + 1'b1;
      end

      // Placed after squash/pop so a fresh entry in a reused slot stays valid.
      if (push) begin
        fifo_q[wr_idx] <= '{valid: 1'b1, addr: ex_addr_i, data: ex_data_i};
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end

      if (drop) ovf_o <= 1'b1;
      stall_o <= (occ_next >= PTR_W'(DEPTH - 1));
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < DEPTH; i++) count_o = count_o + PTR_W'(fifo_q[i].valid);
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to newest so the newest matching entry wins; a same-cycle DM
  // write is newer still.
  always_comb begin
    rs_hit_o  = 1'b0;
    rs_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      automatic logic [IDX_W-1:0] idx = rd_idx + IDX_W'(i);
      if (fifo_q[idx].valid && (fifo_q[idx].addr == rs_addr_i)) begin
        rs_hit_o  = 1'b1;
        rs_data_o = fifo_q[idx].data;
      end
    end
    if (dm_we_i && (dm_addr_i == rs_addr_i)) begin
      rs_hit_o  = 1'b1;
      rs_data_o = dm_data_i;
    end
  end
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^rs_addr_i;
  assign rs_hit_o       = 1'b0;
  assign rs_data_o      = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, self-checking bench for wb_port_arbiter: a scoreboard queue of expected
// register-file writes is checked by a monitor; status outputs are checked inline.
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_we_i, dm_we_i;
  logic [ADDR_W-1:0] ex_addr_i, dm_addr_i, rs_addr_i;
  logic [DATA_W-1:0] ex_data_i, dm_data_i;
  logic              rf_we_o, stall_o, ovf_o, rs_hit_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o, rs_data_o;
  logic [$clog2(DEPTH):0] count_o;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .stall_o(stall_o), .count_o(count_o), .ovf_o(ovf_o),
    .rs_addr_i(rs_addr_i), .rs_hit_o(rs_hit_o), .rs_data_o(rs_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dw, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                       input logic ew, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed);
    dm_we_i = dw; dm_addr_i = da; dm_data_i = dd;
    ex_we_i = ew; ex_addr_i = ea; ex_data_i = ed;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Scoreboard monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {rf_we_o, rf_addr_o}, '0);
      end else begin
        automatic wr_t e = exp_q.pop_front();
        check("wr_en",   rf_we_o,   1'b1);
        check("wr_addr", rf_addr_o, e.addr);
        check("wr_data", rf_data_o, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rs_addr_i = '0;
    idle();
    repeat (2) tick();
    check("rst_rf_we",   rf_we_o,   1'b0);
    check("rst_rf_addr", rf_addr_o, '0);
    check("rst_rf_data", rf_data_o, '0);
    check("rst_stall",   stall_o,   1'b0);
    check("rst_ovf",     ovf_o,     1'b0);
    check("rst_count",   count_o,   '0);
    rst = 1'b0;
    tick();

    // 1: direct EX write with an empty FIFO
    expect_wr(5'd3, 32'h11);
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
    tick();
    check("t1_count", count_o, '0);
    idle();
    tick();
    check("t1_idle_we", rf_we_o, 1'b0);

    // 2: DM and EX in the same cycle
    expect_wr(5'd5, 32'hAA);
    expect_wr(5'd6, 32'hBB);
    drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
    tick();
    check("t2_count_1", count_o, 3'd1);
    idle();
    tick();
    check("t2_count_0", count_o, 3'd0);
    tick();
    check("t2_idle_we", rf_we_o, 1'b0);

    // 3: fill the FIFO, overflow, then drain in order
    for (int i = 0; i < 5; i++) expect_wr(ADDR_W'(20 + i), DATA_W'(32'hD0 + i));
    for (int i = 0; i < 4; i++) expect_wr(ADDR_W'(10 + i), DATA_W'(32'hE0 + i));
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADDR_W'(20 + i), DATA_W'(32'hD0 + i), 1'b1, ADDR_W'(10 + i), DATA_W'(32'hE0 + i));
      tick();
      check($sformatf("t3_count_%0d", i), count_o, (i < 4) ? (i + 1) : 4);
      check($sformatf("t3_stall_%0d", i), stall_o, (i >= 2) ? 1'b1 : 1'b0);
      check($sformatf("t3_ovf_%0d", i),   ovf_o,   (i == 4) ? 1'b1 : 1'b0);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_drain_count_%0d", i), count_o, 3 - i);
      check($sformatf("t3_drain_stall_%0d", i), stall_o, (i == 0) ? 1'b1 : 1'b0);
    end
    tick();
    check("t3_drained_we", rf_we_o, 1'b0);

    // 4: WAW squash of a deferred EX write by a later DM load
    expect_wr(5'd4, 32'h44);
    expect_wr(5'd7, 32'h02);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h01);
    tick();
    check("t4_count_def", count_o, 3'd1);
    drive(1'b1, 5'd7, 32'h02, 1'b0, '0, '0);
    tick();
    check("t4_count_squash", count_o, 3'd0);
    idle();
    tick();
    check("t4_invalid_pop_we", rf_we_o, 1'b0);
    tick();
    check("t4_idle_we", rf_we_o, 1'b0);

    // 5: forwarding lookup on two deferred writes to the same register
    expect_wr(5'd1, 32'hA1);
    expect_wr(5'd2, 32'hA2);
    expect_wr(5'd9, 32'h55);
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9, 32'h33);
    tick();
    drive(1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 32'h44);
    tick();
    check("t5_count", count_o, 3'd2);
    idle();
    rs_addr_i = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check("t5_hit",  rs_hit_o,  1'b1);
    check("t5_data", rs_data_o, 32'h44);
`else
    check("t5_hit",  rs_hit_o,  1'b0);
    check("t5_data", rs_data_o, '0);
`endif
    rs_addr_i = 5'd8;
    #1;
    check("t5_miss", rs_hit_o, 1'b0);
    rs_addr_i = 5'd9;
    drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
    #1;
`ifdef WB_BYPASS_EN
    check("t5_dm_hit",  rs_hit_o,  1'b1);
    check("t5_dm_data", rs_data_o, 32'h55);
`else
    check("t5_dm_hit",  rs_hit_o,  1'b0);
`endif
    tick();
    check("t5_count_squash", count_o, 3'd0);
    idle();
    rs_addr_i = '0;
    repeat (2) begin
      tick();
      check("t5_invalid_pop_we", rf_we_o, 1'b0);
    end
    check("t5_ovf_sticky", ovf_o, 1'b1);

    // 6: reset with entries pending discards them
    for (int i = 0; i < 3; i++) begin
      expect_wr(ADDR_W'(21 + i), DATA_W'(32'hC0 + i));
      drive(1'b1, ADDR_W'(21 + i), DATA_W'(32'hC0 + i), 1'b1, ADDR_W'(25 + i), DATA_W'(32'hF0 + i));
      tick();
    end
    check("t6_count_pend", count_o, 3'd3);
    check("t6_stall_pend", stall_o, 1'b1);
    idle();
    rst = 1'b1;
    tick();
    check("t6_rst_count", count_o, 3'd0);
    check("t6_rst_stall", stall_o, 1'b0);
    check("t6_rst_we",    rf_we_o, 1'b0);
    check("t6_rst_ovf",   ovf_o,   1'b0);
    rst = 1'b0;
    repeat (6) tick();
    check("t6_after_we",    rf_we_o, 1'b0);
    check("t6_after_count", count_o, 3'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
